// File: rtl/sprite_pal_encoder.sv
// sprite_pal_encoder
//   Converts a raster stream of RGB888 pixels into 4-bit palette indices and
//   writes them to sprite memory, one write per accepted pixel.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   start       begins a sprite load when sampled high in IDLE
//   pix_valid   pix_color holds a valid pixel
//   pix_color   RGB888 pixel, raster order
//   pix_ready   high only in LOAD (decoded from state)
//   wr_en       sprite-memory write strobe (registered)
//   wr_address  write address = ordinal of the pixel within the load
//   wr_data     palette index, or MISS_INDEX for an unmatched colour
//   busy        high in any state other than IDLE
//   done        one-cycle pulse when a load completes
//   miss_count  unmatched pixels in the current/last load, saturates at 511
//   error       sticky, high when miss_count is non-zero
module sprite_pal_encoder #(
    parameter int unsigned NUM_PIXELS = 441,
    parameter logic [3:0]  MISS_INDEX = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [23:0] pix_color,
    output logic        pix_ready,
    output logic        wr_en,
    output logic [8:0]  wr_address,
    output logic [3:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [8:0]  miss_count,
    output logic        error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [8:0] LAST_PIX = 9'(NUM_PIXELS - 1);

    state_t      state;
    state_t      state_nx;

    logic        accept;
    logic        load_start;
    logic [8:0]  pix_cnt;

    // Stage 1: accepted pixel waiting for its palette lookup/write.
    logic        s1_valid;
    logic [23:0] s1_color;
    logic [8:0]  s1_addr;
    logic [3:0]  s1_index;
    logic        s1_miss;

    logic        busy_nx;
    logic        done_nx;

    assign accept     = pix_ready && pix_valid;
    assign load_start = (state == ST_IDLE) && start;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. FLUSH waits for the in-flight pixel to be written,
    // so the final write always lands while still in FLUSH.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_LOAD;
            ST_LOAD:  if (accept && (pix_cnt == LAST_PIX)) state_nx = ST_FLUSH;
            ST_FLUSH: if (!s1_valid) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Output decode. busy/done are registered from the next state so they
    // line up exactly with the state register.
    always_comb begin
        pix_ready = (state == ST_LOAD);
        busy_nx   = (state_nx != ST_IDLE);
        done_nx   = (state_nx == ST_DONE);
    end

    // Pixel counter and stage-1 capture
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_color <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (load_start) begin
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 9'd1;
            end
            if (accept) begin
                s1_color <= pix_color;
                s1_addr  <= pix_cnt;
            end
        end
    end

    // Fixed palette lookup (exact 24-bit match)
    always_comb begin
        s1_index = MISS_INDEX;
        s1_miss  = 1'b0;
        case (s1_color)
            24'h800080: s1_index = 4'd0;
            24'hF83800: s1_index = 4'd1;
            24'hEA9A30: s1_index = 4'd2;
            24'hEF9D34: s1_index = 4'd3;
            24'h227DBB: s1_index = 4'd4;
            24'hFFA440: s1_index = 4'd5;
            24'hAC7C00: s1_index = 4'd6;
            default: begin
                s1_index = MISS_INDEX;
                s1_miss  = 1'b1;
            end
        endcase
    end

    // Stage 2: registered write port and status
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            miss_count <= '0;
            error      <= 1'b0;
        end else begin
            busy  <= busy_nx;
            done  <= done_nx;
            wr_en <= s1_valid;
            if (s1_valid) begin
                wr_address <= s1_addr;
                wr_data    <= s1_index;
            end
            // A load can only start once the pipe has drained, so clearing
            // and counting never collide.
            if (load_start) begin
                miss_count <= '0;
                error      <= 1'b0;
            end else if (s1_valid && s1_miss) begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + 9'd1;
                end
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_pal_encoder.sv
// tb_sprite_pal_encoder
//   Directed bench for sprite_pal_encoder. Stimulus pushes expected writes
//   into a scoreboard queue; a negedge monitor pops and compares on wr_en and
//   checks the completion pulse.
`timescale 1ns/1ps
module tb_sprite_pal_encoder;

    localparam int NPIX = 441;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_color = '0;
    logic        pix_ready;
    logic        wr_en;
    logic [8:0]  wr_address;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;
    logic [8:0]  miss_count;
    logic        error;

    sprite_pal_encoder #(
        .NUM_PIXELS (NPIX),
        .MISS_INDEX (4'h0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_color  (pix_color),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .miss_count (miss_count),
        .error      (error)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Hand-computed colour table: colour -> expected index, miss flag
    logic [23:0] tbl_col  [0:8] = '{24'h800080, 24'hF83800, 24'hEA9A30, 24'hEF9D34,
                                    24'h227DBB, 24'hFFA440, 24'hAC7C00, 24'hEA9A31,
                                    24'h123456};
    logic [3:0]  tbl_idx  [0:8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0};
    bit          tbl_miss [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

    typedef struct {
        logic [8:0] addr;
        logic [3:0] data;
        int         miss;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    bit in_load  = 0;
    bit idle     = 1;
    int k        = 0;
    int exp_miss = 0;
    int last_acc = 0;
    int done_cnt = 0;
    int wr_total = 0;
    bit prev_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void lookup(input logic [23:0] c, output logic [3:0] idx, output bit m);
        idx = 4'd0;
        m   = 1;
        for (int unsigned i = 0; i < 9; i++) begin
            if (tbl_col[i] == c) begin
                idx = tbl_idx[i];
                m   = tbl_miss[i];
            end
        end
    endfunction

    // One stimulus slot: drive just after the falling edge, sampled at the next rising edge.
    task automatic drive(input logic s, input logic v, input logic [23:0] c);
        logic [3:0] idx;
        bit         m;
        exp_t       ent;
        @(negedge Clk);
        #1;
        start     = s;
        pix_valid = v;
        pix_color = c;
        chk("pix_ready", pix_ready, in_load);
        if (v && in_load) begin
            lookup(c, idx, m);
            if (m && exp_miss < 511) exp_miss++;
            ent.addr = 9'(k);
            ent.data = idx;
            ent.miss = exp_miss;
            sb.push_back(ent);
            k++;
            last_acc = cyc + 1;
            if (k == NPIX) in_load = 0;
        end else if (s && idle) begin
            idle     = 0;
            in_load  = 1;
            k        = 0;
            exp_miss = 0;
        end
    endtask

    task automatic wait_done(input logic hold_v, input logic [23:0] c);
        int base;
        bit got;
        base = done_cnt;
        got  = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1'b0, hold_v, c);
            if (done_cnt != base) got = 1;
        end
        chk("done_timeout", got, 1);
        idle = 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_ready"},  pix_ready,  0);
        chk({tag, "_wr_en"},      wr_en,      0);
        chk({tag, "_wr_address"}, wr_address, 0);
        chk({tag, "_wr_data"},    wr_data,    0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_miss_count"}, miss_count, 0);
        chk({tag, "_error"},      error,      0);
    endtask

    // Monitor / scoreboard
    exp_t e;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (wr_en) begin
                wr_total++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: actual addr=%0d data=%0d, required no write (t=%0t)",
                             wr_address, wr_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_address", wr_address, e.addr);
                    chk("wr_data",    wr_data,    e.data);
                    chk("wr_miss_count", miss_count, e.miss);
                    chk("wr_error",   error,      (e.miss != 0));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_latency",    cyc - last_acc, 2);
                chk("done_single",     prev_done, 0);
                chk("done_sb_empty",   sb.size(), 0);
                chk("done_miss_count", miss_count, exp_miss);
                chk("done_busy",       busy, 1);
            end
            prev_done = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int v;

        // Reset state
        #1 Reset = 1'b1;
        @(negedge Clk);
        #1;
        check_all_zero("rst");
        @(negedge Clk);
        #2 Reset = 1'b0;

        // A: 441 x F83800, continuous
        w0 = wr_total;
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < NPIX; i++) drive(1'b0, 1'b1, 24'hF83800);
        wait_done(1'b0, 24'h0);
        chk("A_writes", wr_total - w0, NPIX);
        chk("A_miss", miss_count, 0);
        chk("A_error", error, 0);
        drive(1'b0, 1'b0, 24'h0);
        chk("A_busy_idle", busy, 0);

        // B: alternating 227DBB / 123456
        w0 = wr_total;
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < NPIX; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 24'h227DBB : 24'h123456);
        wait_done(1'b0, 24'h0);
        chk("B_writes", wr_total - w0, NPIX);
        chk("B_miss", miss_count, 220);
        chk("B_error", error, 1);
        repeat (3) drive(1'b0, 1'b0, 24'h0);
        chk("B_miss_hold", miss_count, 220);
        chk("B_error_hold", error, 1);

        // C: random bubbles in pix_valid
        w0 = wr_total;
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 4000 && in_load; i++) begin
            v = $urandom_range(0, 1);
            if (v != 0) drive(1'b0, 1'b1, tbl_col[i % 7]);
            else        drive(1'b0, 1'b0, 24'($urandom()));
        end
        chk("C_all_accepted", in_load, 0);
        wait_done(1'b0, 24'h0);
        chk("C_writes", wr_total - w0, NPIX);

        // D: reset mid-load after pixel 100
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i <= 100; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 24'hEA9A30 : 24'h123456);
        @(posedge Clk);
        #2 pix_valid = 1'b0;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check_all_zero("D_rst");
        sb.delete();
        in_load = 0;
        idle    = 1;
        @(negedge Clk);
        #2 Reset = 1'b0;
        w0 = wr_total;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 24'hF83800);
        chk("D_no_write_after_release", wr_total - w0, 0);
        drive(1'b0, 1'b0, 24'h0);
        w0 = wr_total;
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < NPIX; i++) drive(1'b0, 1'b1, 24'hEF9D34);
        wait_done(1'b0, 24'h0);
        chk("D_writes", wr_total - w0, NPIX);

        // E: start pulsed in LOAD, pix_valid held after final acceptance
        w0 = wr_total;
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < NPIX; i++)
            drive((i == 10 || i == 200 || i == NPIX - 1) ? 1'b1 : 1'b0, 1'b1, 24'hFFA440);
        wait_done(1'b1, 24'hFFA440);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 24'hFFA440);
        chk("E_writes", wr_total - w0, NPIX);
        chk("E_busy_idle", busy, 0);
        drive(1'b0, 1'b0, 24'h0);

        // F: every palette colour plus EA9A31
        w0 = wr_total;
        drive(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, tbl_col[i]);
        for (int i = 8; i < NPIX; i++) drive(1'b0, 1'b1, tbl_col[i % 7]);
        wait_done(1'b0, 24'h0);
        chk("F_writes", wr_total - w0, NPIX);
        chk("F_miss", miss_count, 1);
        chk("F_error", error, 1);

        repeat (3) drive(1'b0, 1'b0, 24'h0);
        chk("final_sb_empty", sb.size(), 0);
        chk("done_pulses", done_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_pal_encoder.md
SPRITE_PAL_ENCODER -- requirements
Module: sprite_pal_encoder

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 441, meaning the number of pixels per sprite load (21x21).
REQ-002 SHALL have parameter MISS_INDEX, default 4'h0, meaning the index written for a colour with no palette match (transparent key).
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a sprite load when sampled high in IDLE.
REQ-006 SHALL have port pix_valid  input  1  pix_color holds a valid pixel.
REQ-007 SHALL have port pix_color  input  24  RGB888 pixel, raster order.
REQ-008 SHALL have port pix_ready  output  1  encoder accepts a pixel this cycle.
REQ-009 SHALL have port wr_en  output  1  sprite-memory write strobe.
REQ-010 SHALL have port wr_address  output  9  sprite-memory write address.
REQ-011 SHALL have port wr_data  output  4  palette index to write.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a load completes.
REQ-014 SHALL have port miss_count  output  9  number of unmatched pixels in the current or last load.
REQ-015 SHALL have port error  output  1  sticky; high if miss_count is non-zero.

Function
REQ-016 SHALL hold a fixed 7-entry palette: 0=800080, 1=F83800, 2=EA9A30, 3=EF9D34, 4=227DBB, 5=FFA440, 6=AC7C00.
REQ-017 SHALL encode each accepted pixel as the index of the exact 24-bit palette match, or MISS_INDEX if no entry matches.
REQ-018 SHALL implement the states IDLE, LOAD, FLUSH and DONE.
REQ-019 SHALL go from IDLE to LOAD on start=1, clearing the pixel counter, miss_count and error on that edge.
REQ-020 SHALL drive pix_ready=1 only in LOAD.
REQ-021 SHALL accept a pixel only on a cycle with pix_valid=1 and pix_ready=1, and SHALL ignore pix_color on all other cycles.
REQ-022 SHALL, for a pixel accepted on edge N, drive wr_en=1 for exactly one cycle after edge N+1, with wr_data equal to its index and wr_address equal to its ordinal k (0-based).
REQ-023 SHALL keep wr_en low in every cycle that does not follow an accepted pixel; bubbles in pix_valid produce no writes and do not advance the address.
REQ-024 SHALL increment miss_count in the same cycle that a miss is written, and SHALL saturate miss_count at 511.
REQ-025 SHALL set error in the same cycle that miss_count becomes non-zero.
REQ-026 SHALL go from LOAD to FLUSH on acceptance of pixel NUM_PIXELS-1, so that at most NUM_PIXELS pixels are accepted per load.
REQ-027 SHALL perform the final write while in FLUSH, then enter DONE for one cycle with done=1, then return to IDLE.
REQ-028 SHALL ignore start in LOAD, FLUSH and DONE.
REQ-029 SHALL hold miss_count and error after DONE until the next start.
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs other than pix_ready, which is decoded from state only.

Reset
REQ-031 SHALL, on Reset=1 at any time (including mid-load), immediately force: state IDLE, pix_ready=0, wr_en=0, wr_address=0, wr_data=0, busy=0, done=0, miss_count=0, error=0.
REQ-032 SHALL not issue any write, including a pending pipelined write, after Reset deasserts; the next load begins only on a new start.

Verification
REQ-033 The bench SHALL cover: start, 441 pixels of F83800 with continuous pix_valid -> 441 writes at addresses 0..440, all with data 1; done high exactly 2 cycles after the final acceptance; miss_count=0.
REQ-034 The bench SHALL cover: a load of alternating 227DBB and 123456 -> data alternating 4 and 0; miss_count=220; error=1 after the first miss and still 1 after done.
REQ-035 The bench SHALL cover: pix_valid toggled randomly during a load -> addresses contiguous with no gaps; wr_en count = 441; no write while pix_valid was low.
REQ-036 The bench SHALL cover: Reset asserted after pixel 100 -> all outputs 0 asynchronously; no write after release; a subsequent start writes from address 0.
REQ-037 The bench SHALL cover: start pulsed in LOAD, and pix_valid held high after the final acceptance -> no restart and no extra acceptance; pix_ready=0 in FLUSH, DONE and IDLE.
REQ-038 The bench SHALL cover: each of the 7 palette colours, plus EA9A31 -> indices 0..6, and MISS_INDEX for EA9A31.
